// File: rtl/disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment display blocks.
package disp_pkg;

   localparam int N_DIGITS = 4;
   localparam logic [N_DIGITS-1:0] AN_OFF = 4'b1111;

   typedef logic [1:0] digit_idx_t;
   typedef logic [3:0] bcd_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: tick is high for one cycle out of every PRESCALE.
module tick_gen #(
   parameter int PRESCALE = 50000
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   // A one-cycle prescaler still needs a 1-bit counter that simply holds 0.
   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk) begin
      if (rst || tick) cnt <= '0;
      else             cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/bcd_scan_mux.sv
// Four-digit BCD display scanner with frame-synchronous double buffering and
// optional leading-zero blanking; outputs feed a BCD-to-7-segment decoder.
module bcd_scan_mux
   import disp_pkg::*;
#(
   parameter int PRESCALE = 50000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic [4*N_DIGITS-1:0] value,
   input  logic [N_DIGITS-1:0]   dp_in,
   input  logic                  blank_lz,
   output bcd_t                  digit,
   output logic [N_DIGITS-1:0]   an,
   output logic                  dp_n,
   output logic                  frame_done
);

   // load is a bare strobe with no ready: every cycle it is high is accepted,
   // and the most recent capture before a frame boundary is the one shown.

   logic tick;

   tick_gen #(.PRESCALE(PRESCALE)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick)
   );

   digit_idx_t            idx, idx_n;
   logic [4*N_DIGITS-1:0] disp_val, disp_val_n, pend_val;
   logic [N_DIGITS-1:0]   disp_dp, disp_dp_n, pend_dp;
   logic                  pend_vld;
   logic                  boundary;
   logic [N_DIGITS-1:0]   blank;
   bcd_t                  digit_n;
   logic [N_DIGITS-1:0]   an_n;
   logic                  dp_n_n;

   // Output registers are fed from next-state values so anode, digit and
   // frame_done all switch on the same edge as the index.
   always_comb begin
      boundary   = tick && (idx == 2'd3);
      idx_n      = tick ? idx + 2'd1 : idx;
      disp_val_n = (boundary && pend_vld) ? pend_val : disp_val;
      disp_dp_n  = (boundary && pend_vld) ? pend_dp  : disp_dp;

      blank    = '0;
      blank[3] = blank_lz && (disp_val_n[15:12] == 4'd0);
      blank[2] = blank[3] && (disp_val_n[11:8]  == 4'd0);
      blank[1] = blank[2] && (disp_val_n[7:4]   == 4'd0);

      digit_n = disp_val_n[{idx_n, 2'b00} +: 4];
      an_n    = blank[idx_n] ? AN_OFF : ~(4'b0001 << idx_n);
      dp_n_n  = blank[idx_n] | ~disp_dp_n[idx_n];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx        <= '0;
         disp_val   <= '0;
         disp_dp    <= '0;
         pend_val   <= '0;
         pend_dp    <= '0;
         pend_vld   <= 1'b0;
         digit      <= '0;
         an         <= AN_OFF;
         dp_n       <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         idx      <= idx_n;
         disp_val <= disp_val_n;
         disp_dp  <= disp_dp_n;
         if (load) begin
            pend_val <= value;
            pend_dp  <= dp_in;
            pend_vld <= 1'b1;
         end else if (boundary) begin
            pend_vld <= 1'b0;
         end
         digit      <= digit_n;
         an         <= an_n;
         dp_n       <= dp_n_n;
         frame_done <= boundary;
      end
   end

endmodule

// File: tb/tb_bcd_scan_mux.sv
// Directed bench for bcd_scan_mux: PRESCALE=4 main instance plus a PRESCALE=1 instance.
module tb_bcd_scan_mux;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic        blank_lz = 1'b0;

   logic [3:0]  digit, an, digit1, an1;
   logic        dp_n, frame_done, dp_n1, frame_done1;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   bcd_scan_mux #(.PRESCALE(4)) dut4 (
      .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
      .blank_lz(blank_lz), .digit(digit), .an(an), .dp_n(dp_n),
      .frame_done(frame_done)
   );

   bcd_scan_mux #(.PRESCALE(1)) dut1 (
      .clk(clk), .rst(rst), .load(load), .value(value), .dp_in(dp_in),
      .blank_lz(blank_lz), .digit(digit1), .an(an1), .dp_n(dp_n1),
      .frame_done(frame_done1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks one 4-cycle slot of dut4; optionally pulses load at cycle ld_c.
   task automatic check_slot(input string tag, input logic [3:0] a_exp,
                             input logic [3:0] d_exp, input logic dpn_exp,
                             input logic first, input int ld_c,
                             input logic [15:0] ld_v, input logic [3:0] ld_d);
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("%s an c%0d", tag, c), {12'd0, an}, {12'd0, a_exp});
         chk($sformatf("%s digit c%0d", tag, c), {12'd0, digit}, {12'd0, d_exp});
         chk($sformatf("%s dp_n c%0d", tag, c), {15'd0, dp_n}, {15'd0, dpn_exp});
         chk($sformatf("%s frame_done c%0d", tag, c), {15'd0, frame_done},
             {15'd0, (first && c == 0)});
         if (c == ld_c) begin
            value = ld_v;
            dp_in = ld_d;
            load  = 1'b1;
         end
         step();
         load = 1'b0;
      end
   endtask

   task automatic wait_frame(input string tag);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (frame_done !== 1'b1 && n < 40);
      chk({tag, " frame_done seen"}, {15'd0, frame_done}, 16'd1);
   endtask

   initial begin
      // Reset and scan order
      step();
      chk("reset an", {12'd0, an}, 16'hF);
      chk("reset digit", {12'd0, digit}, 16'h0);
      chk("reset dp_n", {15'd0, dp_n}, 16'd1);
      chk("reset frame_done", {15'd0, frame_done}, 16'd0);
      chk("reset an1", {12'd0, an1}, 16'hF);
      rst   = 1'b0;
      value = 16'h1234;
      dp_in = 4'b0100;
      load  = 1'b1;
      step();
      load = 1'b0;
      chk("release an", {12'd0, an}, 16'hE);
      chk("release digit", {12'd0, digit}, 16'h0);
      wait_frame("f1234");
      check_slot("f1234 s0", 4'b1110, 4'd4, 1'b1, 1'b1, -1, 16'h0, 4'h0);
      check_slot("f1234 s1", 4'b1101, 4'd3, 1'b1, 1'b0, -1, 16'h0, 4'h0);
      check_slot("f1234 s2", 4'b1011, 4'd2, 1'b0, 1'b0, -1, 16'h0, 4'h0);
      check_slot("f1234 s3", 4'b0111, 4'd1, 1'b1, 1'b0, -1, 16'h0, 4'h0);

      // Tear-free update: load lands while idx=1
      check_slot("tear s0", 4'b1110, 4'd4, 1'b1, 1'b1, -1, 16'h0, 4'h0);
      check_slot("tear s1", 4'b1101, 4'd3, 1'b1, 1'b0, 0, 16'h5678, 4'b0000);
      check_slot("tear s2", 4'b1011, 4'd2, 1'b0, 1'b0, -1, 16'h0, 4'h0);
      check_slot("tear s3", 4'b0111, 4'd1, 1'b1, 1'b0, -1, 16'h0, 4'h0);
      check_slot("f5678 s0", 4'b1110, 4'd8, 1'b1, 1'b1, 0, 16'h1111, 4'b0000);
      check_slot("f5678 s1", 4'b1101, 4'd7, 1'b1, 1'b0, -1, 16'h0, 4'h0);
      check_slot("f5678 s2", 4'b1011, 4'd6, 1'b1, 1'b0, -1, 16'h0, 4'h0);

      // Load at the boundary tick while 1111 is pending
      check_slot("f5678 s3", 4'b0111, 4'd5, 1'b1, 1'b0, 3, 16'h0009, 4'b0000);
      chk("pend_vld across boundary", {15'd0, dut4.pend_vld}, 16'd1);
      check_slot("f1111 s0", 4'b1110, 4'd1, 1'b1, 1'b1, -1, 16'h0, 4'h0);
      check_slot("f1111 s1", 4'b1101, 4'd1, 1'b1, 1'b0, -1, 16'h0, 4'h0);
      check_slot("f1111 s2", 4'b1011, 4'd1, 1'b1, 1'b0, -1, 16'h0, 4'h0);
      check_slot("f1111 s3", 4'b0111, 4'd1, 1'b1, 1'b0, -1, 16'h0, 4'h0);
      check_slot("f0009 s0", 4'b1110, 4'd9, 1'b1, 1'b1, 0, 16'h0040, 4'b1000);
      check_slot("f0009 s1", 4'b1101, 4'd0, 1'b1, 1'b0, -1, 16'h0, 4'h0);
      check_slot("f0009 s2", 4'b1011, 4'd0, 1'b1, 1'b0, -1, 16'h0, 4'h0);
      check_slot("f0009 s3", 4'b0111, 4'd0, 1'b1, 1'b0, -1, 16'h0, 4'h0);

      // Leading-zero blanking
      blank_lz = 1'b1;
      check_slot("f0040 s0", 4'b1110, 4'd0, 1'b1, 1'b1, 0, 16'h0000, 4'b1111);
      check_slot("f0040 s1", 4'b1101, 4'd4, 1'b1, 1'b0, -1, 16'h0, 4'h0);
      check_slot("f0040 s2", 4'b1111, 4'd0, 1'b1, 1'b0, -1, 16'h0, 4'h0);
      check_slot("f0040 s3", 4'b1111, 4'd0, 1'b1, 1'b0, -1, 16'h0, 4'h0);
      check_slot("f0000 s0", 4'b1110, 4'd0, 1'b0, 1'b1, 0, 16'hA000, 4'b0000);
      check_slot("f0000 s1", 4'b1111, 4'd0, 1'b1, 1'b0, -1, 16'h0, 4'h0);
      check_slot("f0000 s2", 4'b1111, 4'd0, 1'b1, 1'b0, -1, 16'h0, 4'h0);
      check_slot("f0000 s3", 4'b1111, 4'd0, 1'b1, 1'b0, -1, 16'h0, 4'h0);
      blank_lz = 1'b0;

      // Invalid code passes through
      check_slot("fA000 s0", 4'b1110, 4'd0, 1'b1, 1'b1, -1, 16'h0, 4'h0);
      check_slot("fA000 s1", 4'b1101, 4'd0, 1'b1, 1'b0, -1, 16'h0, 4'h0);
      check_slot("fA000 s2", 4'b1011, 4'd0, 1'b1, 1'b0, -1, 16'h0, 4'h0);
      check_slot("fA000 s3", 4'b0111, 4'hA, 1'b1, 1'b0, -1, 16'h0, 4'h0);

      // PRESCALE=1 instance: one slot per cycle, frame pulse every 4 cycles
      begin
         int n;
         logic [3:0] a_exp;
         n = 0;
         do begin
            step();
            n++;
         end while (frame_done1 !== 1'b1 && n < 20);
         chk("p1 frame_done seen", {15'd0, frame_done1}, 16'd1);
         for (int c = 0; c < 8; c++) begin
            case (c % 4)
               0: a_exp = 4'b1110;
               1: a_exp = 4'b1101;
               2: a_exp = 4'b1011;
               default: a_exp = 4'b0111;
            endcase
            chk($sformatf("p1 an c%0d", c), {12'd0, an1}, {12'd0, a_exp});
            chk($sformatf("p1 digit c%0d", c), {12'd0, digit1},
                (c % 4 == 3) ? 16'hA : 16'h0);
            chk($sformatf("p1 frame_done c%0d", c), {15'd0, frame_done1},
                (c % 4 == 0) ? 16'd1 : 16'd0);
            step();
         end
      end

      // Reset mid-operation with data pending
      wait_frame("pre-reset");
      check_slot("rst s0", 4'b1110, 4'd0, 1'b1, 1'b1, 0, 16'h7777, 4'b1111);
      check_slot("rst s1", 4'b1101, 4'd0, 1'b1, 1'b0, -1, 16'h0, 4'h0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst an", {12'd0, an}, 16'hF);
      chk("midrst dp_n", {15'd0, dp_n}, 16'd1);
      chk("midrst frame_done", {15'd0, frame_done}, 16'd0);
      step();
      chk("post-rst an", {12'd0, an}, 16'hE);
      chk("post-rst digit", {12'd0, digit}, 16'h0);
      wait_frame("post-rst");
      check_slot("post-rst s0", 4'b1110, 4'd0, 1'b1, 1'b1, -1, 16'h0, 4'h0);
      check_slot("post-rst s1", 4'b1101, 4'd0, 1'b1, 1'b0, -1, 16'h0, 4'h0);
      check_slot("post-rst s2", 4'b1011, 4'd0, 1'b1, 1'b0, -1, 16'h0, 4'h0);
      check_slot("post-rst s3", 4'b0111, 4'd0, 1'b1, 1'b0, -1, 16'h0, 4'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
